// File: rtl/eve_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eve_pkg : shared gene word layout, sentinel and writer FSM encoding  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package eve_pkg;

    localparam int GENE_W      = 64;
    localparam int ID_MSB      = 63;
    localparam int ID_LSB      = 56;
    localparam int TYPE_BIT    = 55;
    localparam int KEY_MSB     = 47;
    localparam int KEY_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    localparam logic [7:0]        INVALID_ID   = 8'hFF;
    localparam logic [GENE_W-1:0] EOG_SENTINEL = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_COLLECT = 3'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_TERM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

    typedef logic [GENE_W-1:0] gene_t;

    function automatic logic [7:0] gene_id(input gene_t g);
        return g[ID_MSB:ID_LSB];
    endfunction

    function automatic logic gene_is_conn(input gene_t g);
        return g[TYPE_BIT];
    endfunction

    function automatic logic [15:0] gene_key(input gene_t g);
        return g[KEY_MSB:KEY_LSB];
    endfunction

    function automatic logic [31:0] gene_payload(input gene_t g);
        return g[PAYLOAD_MSB:PAYLOAD_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/eve_gene_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eve_gene_fifo : synchronous gene FIFO, head read from storage flops  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module eve_gene_fifo
    import eve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [GENE_W-1:0] push_data,
    input  logic              pop,
    output logic [GENE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [GENE_W-1:0] mem_q [DEPTH];
    logic [GENE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign occupancy = count_q;
    assign head      = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/eve_child_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eve_child_writer : filters child genes, buffers them and writes the  |
// | child genome plus end-of-genome sentinel.            Rev 1.0         |
// +----------------------------------------------------------------------+
module eve_child_writer
    import eve_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_genes,
    input  logic              flush,
    input  logic [63:0]       in_gene,
    input  logic              in_valid,
    output logic              in_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] gene_count,
    output logic [ADDR_W-1:0] node_count,
    output logic [ADDR_W-1:0] conn_count,
    output logic              overflow,
    output logic              limit_err
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FILL_W = ADDR_W + 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  max_q, max_d;
    logic [ADDR_W-1:0]  gene_count_q, gene_count_d;
    logic [ADDR_W-1:0]  node_count_q, node_count_d;
    logic [ADDR_W-1:0]  conn_count_q, conn_count_d;
    logic               overflow_q, overflow_d;
    logic               limit_err_q, limit_err_d;
    logic               in_stall_q, in_stall_d;

    logic [GENE_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_occ;
    logic               fifo_push;
    logic               fifo_pop;

    logic               collecting;
    logic               writing;
    logic               word_ok;
    logic               drop_full;
    logic               limit_hit;
    logic [FILL_W-1:0]  fill;

    eve_gene_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_gene),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    assign collecting = (state_q == ST_COLLECT);
    assign writing    = (collecting || (state_q == ST_DRAIN)) && !fifo_empty;
    assign fifo_pop   = writing && mem_ready;

    // Buffered plus written genes never exceeds max; a same-cycle pop keeps the sum.
    assign fill      = FILL_W'(gene_count_q) + FILL_W'(fifo_occ);
    assign limit_hit = (fill >= FILL_W'(max_q));

    assign word_ok   = collecting && in_valid && (gene_id(in_gene) != INVALID_ID);
    assign drop_full = word_ok && fifo_full && !fifo_pop;
    assign fifo_push = word_ok && !drop_full && !limit_hit;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        max_d        = max_q;
        gene_count_d = gene_count_q;
        node_count_d = node_count_q;
        conn_count_d = conn_count_q;
        overflow_d   = overflow_q;
        limit_err_d  = limit_err_q;
        in_stall_d   = (fifo_occ >= CNT_W'(FIFO_DEPTH - 1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_COLLECT;
                    base_d       = base_addr;
                    max_d        = max_genes;
                    gene_count_d = '0;
                    node_count_d = '0;
                    conn_count_d = '0;
                    overflow_d   = 1'b0;
                    limit_err_d  = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_pop) begin
            gene_count_d = gene_count_q + ADDR_W'(1);
            if (gene_is_conn(fifo_head)) begin
                conn_count_d = conn_count_q + ADDR_W'(1);
            end else begin
                node_count_d = node_count_q + ADDR_W'(1);
            end
        end

        if (drop_full) begin
            overflow_d = 1'b1;
        end
        if (word_ok && !drop_full && limit_hit) begin
            limit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            max_q        <= '0;
            gene_count_q <= '0;
            node_count_q <= '0;
            conn_count_q <= '0;
            overflow_q   <= 1'b0;
            limit_err_q  <= 1'b0;
            in_stall_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            max_q        <= max_d;
            gene_count_q <= gene_count_d;
            node_count_q <= node_count_d;
            conn_count_q <= conn_count_d;
            overflow_q   <= overflow_d;
            limit_err_q  <= limit_err_d;
            in_stall_q   <= in_stall_d;
        end
    end

    // Write port is a pure function of flops, so it holds steady while mem_ready is low.
    assign mem_we    = writing || (state_q == ST_TERM);
    assign mem_addr  = mem_we ? (base_q + gene_count_q) : '0;
    assign mem_wdata = (state_q == ST_TERM) ? EOG_SENTINEL :
                       (writing ? fifo_head : '0);

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign in_stall   = in_stall_q;
    assign gene_count = gene_count_q;
    assign node_count = node_count_q;
    assign conn_count = conn_count_q;
    assign overflow   = overflow_q;
    assign limit_err  = limit_err_q;

endmodule
`default_nettype wire

// File: doc/eve_child_writer.md
# eve_child_writer

Downstream stage of the EvE crossover engine. It samples the 64-bit child-gene word stream and discards words tagged invalid (ID 8'hFF). Surviving genes are buffered in a small FIFO and written sequentially into the child-genome memory region. After a flush it terminates the genome with an end-of-genome sentinel and reports gene, node and connection counts to the controller.

## Interface
- ADDR_W, 10, genome memory address width
- FIFO_DEPTH, 4, gene buffer depth (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr/max_genes, begins collection
- base_addr  in  ADDR_W  first write address of child genome
- max_genes  in  ADDR_W  gene capacity, excluding sentinel
- flush  in  1  one-cycle pulse from controller: parents exhausted, finish genome
- in_gene  in  64  crossover output word: [63:56] ID, [55] type (1 = connection, 0 = node), [47:32] node/conn key, [31:0] payload
- in_valid  in  1  in_gene is a new word this cycle
- in_stall  out  1  FIFO holds ≥ FIFO_DEPTH-1 entries; controller must hold in_valid low
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  64  write data
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after sentinel accepted
- gene_count  out  ADDR_W  genes written (excluding sentinel)
- node_count, conn_count  out  ADDR_W  per-type counts, sum = gene_count
- overflow  out  1  sticky: valid word arrived with FIFO full
- limit_err  out  1  sticky: valid word dropped because max_genes reached

## Operation
- FSM states: IDLE, COLLECT, DRAIN, TERM, DONE.
- IDLE:
  - start → COLLECT.
  - On entry to COLLECT: clear counts and sticky flags; latch base_addr and max_genes.
  - start outside IDLE is ignored.
- COLLECT:
  - A word is accepted when in_valid && in_gene[63:56] ≠ 8'hFF.
  - Accepted word with FIFO full → dropped, overflow set.
  - Accepted word when (FIFO occupancy + gene_count) ≥ max_genes → dropped, limit_err set.
  - Otherwise the word is pushed unmodified.
  - flush → DRAIN. A valid word on the flush cycle is still accepted.
- DRAIN: input ignored; pop FIFO to memory until empty → TERM.
- Write port (COLLECT/DRAIN):
  - Head of FIFO is presented with mem_we = 1, mem_addr = base + gene_count.
  - On mem_we && mem_ready: pop; gene_count += 1; node_count or conn_count += 1 by bit [55].
  - mem_we, mem_addr and mem_wdata stay stable while mem_ready is low.
- TERM:
  - Present sentinel 64'hFFFF_FFFF_FFFF_FFFF at base + gene_count.
  - On acceptance → DONE.
  - Memory region must hold max_genes + 1 words.
- DONE: done = 1 for one cycle → IDLE. Counts and flags hold until next start.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- Reset mid-operation: abort immediately. FIFO is emptied, no further writes, no done.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty.
- Latency: word accepted at cycle N appears on mem_we/mem_wdata at N+1 at the earliest (registered FIFO output).
- Throughput: one write per cycle with mem_ready held high.
- in_stall is registered from occupancy. The threshold leaves one slot to absorb a word already in flight.
- Push and pop on the same cycle with FIFO full is legal: occupancy is unchanged, no overflow.
- done rises one cycle after the sentinel handshake.
- flush in IDLE, DRAIN or TERM is ignored.

## Structure
- Shared eve_pkg holds:
  - gene field positions (ID, TYPE bit 55, key, payload);
  - INVALID_ID = 8'hFF;
  - EOG_SENTINEL = 64'hFFFF_FFFF_FFFF_FFFF;
  - FSM state encoding.
- One sub-module: eve_gene_fifo, a synchronous FIFO with registered head output, full/empty and occupancy outputs.
- Write-address generation and counters live in the top level.

## Test plan
- Basic write: base=0x010, max=8, mem_ready=1. Feed nodes ID 3 (keys 1, 2) and connection ID 3, then flush. → Writes at 0x010–0x012, sentinel at 0x013; gene=3, node=2, conn=1; done pulses once.
- Filtering: interleave five words with ID 8'hFF among four valid words. → Only the four valid words are written, in order; gene_count=4.
- Backpressure: mem_ready low for 6 cycles while 4 valid words arrive. → in_stall asserts at occupancy 3. Writes remain stable while stalled. No overflow when in_valid is obeyed; forcing a 5th word sets overflow.
- Limit: max=2, feed 3 valid words. → Third word is dropped; limit_err=1; sentinel at base+2.
- Reset mid-DRAIN: rst with 2 words buffered. → mem_we=0 the next cycle, busy=0, counts 0, no done. A new start runs cleanly.
- Boundary: flush coincident with a valid word, and base=0x3FE. → The word is written at 0x3FE, the sentinel at 0x3FF.
